sram_bus_ctrl: RTL and testbench
================================

# sram_bus_ctrl

Synchronous front-end for the asynchronous 16-bit × 256 `sram` macro. It accepts single read/write requests on a valid/ready interface and sequences the macro's active-low `chip_enable`, `write_enable` and `output_enable` strobes, address and bidirectional data bus with guaranteed setup, pulse and hold cycles. It also returns read data with a one-cycle `done` pulse. It sits directly upstream of `sram` and is the only block that drives its pins.

## Interface
- `ADDR_WIDTH`, 8, SRAM address width.
- `DATA_WIDTH`, 16, SRAM data width.
- `WAIT_CYCLES`, 1, length of the write pulse or read access in clocks. Must be ≥1; 0 is treated as 1.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `done`  out  1  one-cycle pulse on transaction completion (read or write).
- `rsp_rdata`  out  DATA_WIDTH  read data; valid when `done` is high for a read; holds its value until the next read completes.
- `sram_address`  out  ADDR_WIDTH  to `sram.address`.
- `sram_data`  inout  DATA_WIDTH  to `sram.data`; high-Z unless the controller drives it.
- `sram_chip_enable`  out  1  active low.
- `sram_write_enable`  out  1  active low.
- `sram_output_enable`  out  1  active low.

## Operation
- Accept: a request is taken at a rising edge where `req_valid & req_ready`. At that edge, addr, wdata and write are latched internally. Request inputs are don't-care afterwards.
- All SRAM pins are registered outputs or driven from registered enables. No combinational path from `req_*` to the pins.
- FSM states:
  - **IDLE**: all strobes 1, bus Z, `req_ready`=1. On accept, go to SETUP.
  - **SETUP** (1 cycle): `sram_address`=latched addr, `chip_enable`=0. For a write, the bus drives wdata and `write_enable`=1, `output_enable`=1. For a read, the bus is Z and `output_enable`=0. Go to ACCESS.
  - **ACCESS** (WAIT_CYCLES cycles, down-counter): for a write, `write_enable`=0 and the bus is still driven. For a read, `output_enable`=0 and the bus is Z. For a read, `sram_data` is captured into `rsp_rdata` at the edge ending the last ACCESS cycle. Go to HOLD.
  - **HOLD** (1 cycle): `write_enable`=1, `output_enable`=1, `chip_enable`=0. Address and (for a write) bus data remain stable. `done`=1. Go to IDLE.
- The address is constant from SETUP through HOLD. Write data is stable across the rising edge of `write_enable`.
- The controller never drives `sram_data` while `sram_output_enable`=0. This is an invariant.
- There is no early return from IDLE: consecutive transactions always pass through an IDLE cycle with all strobes high. This provides the read→write bus turnaround.
- Requests presented while `reset`=0 are ignored.

## Timing
- Reset values (at the first edge with `reset`=0, held while low):
  - state IDLE, `req_ready`=1, `done`=0, `rsp_rdata`=0
  - `sram_address`=0
  - `sram_chip_enable`=`sram_write_enable`=`sram_output_enable`=1
  - `sram_data`=Z
- Reset mid-transaction: at the next edge, the FSM aborts to the reset values. No `done` is issued, and `rsp_rdata` returns to 0. A write aborted in ACCESS may leave the SRAM location undefined.
- Latency: accept edge → `done` high in cycle WAIT_CYCLES+2 after acceptance. With the default, `done` occupies the 3rd cycle after the accept edge.
- Throughput: one transaction per WAIT_CYCLES+3 clocks (SETUP + ACCESS + HOLD + IDLE).
- `chip_enable` is low for exactly WAIT_CYCLES+2 cycles per transaction.
- `write_enable` (writes) and `output_enable` (reads) are low for exactly WAIT_CYCLES cycles and WAIT_CYCLES+1 cycles respectively.
- `req_ready` is low from the cycle after acceptance through HOLD.

## Test plan
1. Hold `reset`=0 for 2 cycles with `req_valid`=1 → all strobes 1, bus Z, `done`=0, `rsp_rdata`=0, no transaction started. Release → `req_ready`=1.
2. Write 24 to addr 28, then read addr 28 (WAIT_CYCLES=1):
   - write: `write_enable` low exactly 1 cycle, `chip_enable` low 3 cycles, bus=24 SETUP..HOLD, `done` 3 cycles after accept.
   - read: `rsp_rdata`=24 with `done`, bus never driven by the controller.
3. Overwrite addr 28 with 30, write 0xFFFF to addr 255 and 0x0001 to addr 0, then read all three → 30, 0xFFFF, 0x0001.
4. `req_valid` held high with 4 alternating write/read requests → accepts spaced exactly 4 cycles apart, one `done` per request, and the assertion "bus driven while `output_enable`=0" never fires.
5. Assert `reset`=0 for 1 cycle during ACCESS of a write to addr 5 → next edge: strobes 1, bus Z, no `done`. A subsequent write/read of addr 6 completes normally.
6. With WAIT_CYCLES=3, write then read addr 100 with value 0xA5A5 → `write_enable` low 3 cycles, `done` 5 cycles after each accept, `rsp_rdata`=0xA5A5, accepts spaced 6 cycles.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// ----------------------------------------------------------------------------
// sram_bus_ctrl
//
// Synchronous front-end for an asynchronous single-port SRAM macro. Takes one
// read or write request at a time on a valid/ready handshake and sequences
// the macro's active-low strobes, address and bidirectional data bus through
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES clocks) -> HOLD -> IDLE.
//
// Ports
//   clk                 single clock, rising edge
//   reset               synchronous, active-low reset
//   req_valid/req_ready request handshake; ready is high only in IDLE
//   req_write           1 = write, 0 = read
//   req_addr/req_wdata  request address and write data (latched on accept)
//   done                one-cycle pulse in HOLD when a transaction completes
//   rsp_rdata           last read data; updated only when a read completes
//   sram_address        SRAM address (registered)
//   sram_data           SRAM bidirectional data bus; Z unless writing
//   sram_chip_enable    active-low chip enable (registered)
//   sram_write_enable   active-low write strobe (registered)
//   sram_output_enable  active-low output enable (registered)
// ----------------------------------------------------------------------------
module sram_bus_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_chip_enable,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable
);

    // A zero wait count would give no write pulse at all, so clamp it to 1.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_EFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_e;

    state_e                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  write_q,  write_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  ce_n_q,   ce_n_d;
    logic                  we_n_q,   we_n_d;
    logic                  oe_n_q,   oe_n_d;
    logic                  drive_q,  drive_d;
    logic                  done_q,   done_d;
    logic                  accept;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Next-state and next-pin computation. Pin values are derived from the
    // *next* state so that every SRAM pin leaves a flop aligned with the
    // state it belongs to, with no combinational path from req_* to a pin.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_W'(WAIT_EFF);
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    // Capture at the edge that ends the last access cycle,
                    // while output_enable is still asserted.
                    if (!write_q) begin
                        rdata_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ce_n_d  = (state_d == ST_IDLE);
        we_n_d  = !((state_d == ST_ACCESS) && write_d);
        oe_n_d  = !(((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && !write_d);
        // Write data is driven from SETUP through HOLD so it is stable across
        // the rising edge of write_enable; reads never enable the driver.
        drive_d = write_d && (state_d != ST_IDLE);
        done_d  = (state_d == ST_HOLD);
    end

    // NOTE: reset is sampled on the clock edge only (synchronous), and it
    // overrides any in-flight transaction, including a pending accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            drive_q <= drive_d;
            done_q  <= done_d;
        end
    end

    assign req_ready          = (state_q == ST_IDLE);
    assign done               = done_q;
    assign rsp_rdata          = rdata_q;
    assign sram_address       = addr_q;
    assign sram_chip_enable   = ce_n_q;
    assign sram_write_enable  = we_n_q;
    assign sram_output_enable = oe_n_q;
    assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_bus_ctrl
//
// Directed bench for sram_bus_ctrl. Two controllers (WAIT_CYCLES = 1 and 3)
// each drive a small behavioural async SRAM. Inputs are applied and outputs
// sampled on the falling clock edge; per-transaction strobe widths, done
// position, address/data stability and read data are compared against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_sram_bus_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid_a, valid_b;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;

    logic        ready_a, ready_b, done_a, done_b;
    logic [15:0] rdata_a, rdata_b;
    logic [7:0]  addr_a, addr_b;
    wire  [15:0] data_a, data_b;
    logic        ce_a, we_a, oe_a, ce_b, we_b, oe_b;

    sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done_a), .rsp_rdata(rdata_a),
        .sram_address(addr_a), .sram_data(data_a),
        .sram_chip_enable(ce_a), .sram_write_enable(we_a), .sram_output_enable(oe_a)
    );

    sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done_b), .rsp_rdata(rdata_b),
        .sram_address(addr_b), .sram_data(data_b),
        .sram_chip_enable(ce_b), .sram_write_enable(we_b), .sram_output_enable(oe_b)
    );

    // Behavioural async SRAMs: drive on CE&OE low with WE high, write on WE rise.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    assign data_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a] : 16'bz;
    assign data_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b] : 16'bz;
    always @(posedge we_a) if (ce_a === 1'b0) mem_a[addr_a] = data_a;
    always @(posedge we_b) if (ce_b === 1'b0) mem_b[addr_b] = data_b;

    // Selected-DUT view used by the checking tasks.
    logic        sel;
    wire         cur_ready = sel ? ready_b : ready_a;
    wire         cur_done  = sel ? done_b  : done_a;
    wire  [15:0] cur_rdata = sel ? rdata_b : rdata_a;
    wire  [7:0]  cur_addr  = sel ? addr_b  : addr_a;
    wire  [15:0] cur_data  = sel ? data_b  : data_a;
    wire         cur_ce    = sel ? ce_b    : ce_a;
    wire         cur_we    = sel ? we_b    : we_a;
    wire         cur_oe    = sel ? oe_b    : oe_a;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          viol  = 0;
    int          last_acc;
    bit          cur_wr = 1'b0;
    logic [15:0] hold [2];

    always @(posedge clk) cyc++;

    // Output-enable asserted during a write transaction (when the controller
    // owns the bus), or together with write_enable, is a bus conflict.
    always @(negedge clk) begin
        if (cur_oe == 1'b0 && (cur_wr || cur_we == 1'b0)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_ce",    cur_ce,    1);
        check("rst_we",    cur_we,    1);
        check("rst_oe",    cur_oe,    1);
        check("rst_done",  cur_done,  0);
        check("rst_rdata", cur_rdata, 0);
        check("rst_addr",  cur_addr,  0);
        check("rst_ready", cur_ready, 1);
    endtask

    // Presents one request at a falling edge with the selected DUT idle, then
    // watches it through HOLD and the following IDLE cycle. Returns at the
    // falling edge of that IDLE cycle so a following call accepts back-to-back.
    task automatic do_txn(input bit wr, input logic [7:0] a, input logic [15:0] wd,
                          input logic [15:0] rd_exp, input bit keep_valid, input bit chk_space);
        int          w;
        int          ce_lo, we_lo, oe_lo, rdy_hi, done_n, done_at, bus_bad, adr_bad;
        logic [15:0] exp_r;
        w = sel ? 3 : 1;
        ce_lo = 0; we_lo = 0; oe_lo = 0; rdy_hi = 0;
        done_n = 0; done_at = -1; bus_bad = 0; adr_bad = 0;
        if (!wr) hold[sel] = rd_exp;
        exp_r     = hold[sel];
        cur_wr    = wr;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        check("ready_at_req", cur_ready, 1);
        if (chk_space && last_acc >= 0) check("accept_spacing", cyc - last_acc, w + 3);
        last_acc = cyc;
        @(posedge clk);
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            if (k == 1 && !keep_valid) begin
                valid_a = 1'b0;
                valid_b = 1'b0;
            end
            if (cur_ce == 1'b0) ce_lo++;
            if (cur_we == 1'b0) we_lo++;
            if (cur_oe == 1'b0) oe_lo++;
            if (cur_ready)      rdy_hi++;
            if (cur_done) begin
                done_n++;
                done_at = k;
            end
            if (cur_addr !== a)       adr_bad++;
            if (wr && cur_data !== wd) bus_bad++;
        end
        check("ce_low_cycles",   ce_lo,  w + 2);
        check("we_low_cycles",   we_lo,  wr ? w : 0);
        check("oe_low_cycles",   oe_lo,  wr ? 0 : w + 1);
        check("ready_busy",      rdy_hi, 0);
        check("done_count",      done_n, 1);
        check("done_position",   done_at, w + 2);
        check("addr_stable",     adr_bad, 0);
        check("wdata_stable",    bus_bad, 0);
        check("rsp_rdata",       cur_rdata, exp_r);
        @(negedge clk);
        check("idle_ready",      cur_ready, 1);
        check("idle_done",       cur_done,  0);
        check("idle_ce",         cur_ce,    1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        sel       = 1'b0;
        hold[0]   = 16'h0;
        hold[1]   = 16'h0;
        last_acc  = -1;
        reset     = 1'b0;
        valid_a   = 1'b1;
        valid_b   = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h2A;
        req_wdata = 16'h1234;

        // 1: reset held two cycles with a request pending on both controllers.
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sel = 1'b0; check_reset_vals();
            sel = 1'b1; check_reset_vals();
        end
        sel     = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cur_ready, 1);
        check("post_rst_ce",    cur_ce,    1);

        // 2: write 24 to addr 28, read it back.
        do_txn(1'b1, 8'd28, 16'd24, 16'h0,  1'b0, 1'b0);
        do_txn(1'b0, 8'd28, 16'h0,  16'd24, 1'b0, 1'b0);

        // 3: overwrite and boundary addresses / data.
        do_txn(1'b1, 8'd28,  16'd30,   16'h0, 1'b0, 1'b0);
        do_txn(1'b1, 8'd255, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        do_txn(1'b1, 8'd0,   16'h0001, 16'h0, 1'b0, 1'b0);
        do_txn(1'b0, 8'd28,  16'h0, 16'd30,   1'b0, 1'b0);
        do_txn(1'b0, 8'd255, 16'h0, 16'hFFFF, 1'b0, 1'b0);
        do_txn(1'b0, 8'd0,   16'h0, 16'h0001, 1'b0, 1'b0);

        // 4: req_valid held high, alternating write/read, accepts 4 apart.
        viol     = 0;
        last_acc = -1;
        do_txn(1'b1, 8'h10, 16'h1111, 16'h0,    1'b1, 1'b1);
        do_txn(1'b0, 8'h10, 16'h0,    16'h1111, 1'b1, 1'b1);
        do_txn(1'b1, 8'h11, 16'h2222, 16'h0,    1'b1, 1'b1);
        do_txn(1'b0, 8'h11, 16'h0,    16'h2222, 1'b0, 1'b1);
        check("bus_oe_invariant", viol, 0);

        // 5: reset pulse during ACCESS of a write to addr 5.
        cur_wr    = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'd5;
        req_wdata = 16'h5555;
        valid_a   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        check("abort_in_access_we", cur_we, 0);
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        hold[0] = 16'h0;
        hold[1] = 16'h0;
        check_reset_vals();
        @(negedge clk);
        check("abort_no_done", cur_done, 0);
        do_txn(1'b1, 8'd6, 16'h0C0C, 16'h0,    1'b0, 1'b0);
        do_txn(1'b0, 8'd6, 16'h0,    16'h0C0C, 1'b0, 1'b0);

        // 6: WAIT_CYCLES = 3 controller, accepts 6 apart.
        sel      = 1'b1;
        last_acc = -1;
        do_txn(1'b1, 8'd100, 16'hA5A5, 16'h0,    1'b0, 1'b1);
        do_txn(1'b0, 8'd100, 16'h0,    16'hA5A5, 1'b0, 1'b1);
        check("bus_oe_invariant_all", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
